if_id_fetch_queue: RTL
======================

Name: if_id_fetch_queue

Overview:
- Parametrised successor to the IF/ID segment register.
- Decouples fetch from decode with a DEPTH-entry instruction queue.
- Absorbs synchronous instruction-memory read latency (MEM_LAT cycles).
- Carries PC and branch-prediction metadata (pred bit, predicted NPC) alongside each instruction.
- Replaces single-register stall/clear with valid/ready handshakes and a flush.

Parameters:
- XLEN, 32, PC/address and predicted-NPC width
- ILEN, 32, instruction width
- DEPTH, 4, queue entries (power of two, 2..16)
- MEM_LAT, 1, instruction-memory read latency in cycles (1 or 2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush (branch mispredict/jump), drops queued and in-flight fetches
- if_valid  in  1  IF presents a fetch request
- if_ready  out  1  queue can accept a fetch request
- if_pc  in  XLEN  PC of the fetch request
- if_pred  in  1  predictor's taken bit for if_pc
- if_npc_pred  in  XLEN  predicted next PC
- imem_en  out  1  instruction-memory read enable
- imem_addr  out  XLEN  byte address; memory indexes [XLEN-1:2]
- imem_rdata  in  ILEN  read data, valid MEM_LAT cycles after imem_en
- id_valid  out  1  head entry valid
- id_ready  in  1  ID consumes head entry
- id_instr  out  ILEN  instruction
- id_pc  out  XLEN  instruction PC
- id_pred  out  1  prediction bit
- id_npc_pred  out  XLEN  predicted NPC
- occupancy  out  $clog2(DEPTH+1)  queued entries, excluding in-flight

Behaviour:
- Interface: one clock clk; reset rst_n asynchronous, active-low. Every register clears on rst_n=0 regardless of clk.
- Reset values:
  - if_ready=0 during reset, combinational after release.
  - id_valid=0, occupancy=0, imem_en=0.
  - id_instr/id_pc/id_pred/id_npc_pred=0.
- Accept:
  - A fetch is accepted when if_valid&&if_ready.
  - imem_en=if_valid&&if_ready and imem_addr=if_pc, both combinational.
  - The metadata {pc, pred, npc_pred} enters a MEM_LAT-stage valid-tagged shift pipeline.
- Arrival: when a pipeline stage exits valid, {imem_rdata, metadata} is written to the FIFO tail that cycle.
- Credit rule:
  - if_ready = !flush && (occupancy + inflight) < DEPTH.
  - inflight counts valid pipeline stages.
  - A same-cycle dequeue does NOT add credit (registered-only path). The queue therefore never overflows, and arrivals are never dropped except by flush.
- Dequeue: on id_valid&&id_ready the head pops. Simultaneous enqueue and dequeue keeps occupancy unchanged. Pointers wrap modulo DEPTH.
- Latency: a fetch accepted at cycle t is visible on id_* at t+MEM_LAT+1 when the queue is empty.
- Output masking: when id_valid=0, all id_* data outputs are forced to 0 (bubble).
- Flush (synchronous, highest priority):
  - Resets pointers and occupancy to 0 and invalidates all in-flight stages.
  - Data arriving in the flush cycle is discarded.
  - if_ready=0 and imem_en=0 in the flush cycle.
  - id_valid=0 from the next cycle.
  - Flush with id_ready=1 is not a consume.
- Reset mid-operation: queued and in-flight state is lost; behaviour matches post-reset.
- Order: strict FIFO; no reordering.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When the FIFO is empty and an arrival occurs, id_* presents the arrival combinationally in the same cycle (id_valid=1).
  - If id_ready=1 it is consumed and not written.
  - Empty-queue latency becomes MEM_LAT.
  - Flush still suppresses bypass.
- Undefined: every arrival is written to the FIFO first; latency is MEM_LAT+1.

Decomposition:
- Package if_id_pkg:
  - ifq_entry_t {instr, pc, pred, npc_pred}
  - ifq_meta_t {pc, pred, npc_pred}
  - default XLEN/ILEN constants
  - NOP_INSTR=32'h0000_0013, reserved for consumers that substitute NOPs
- Sub-module ifq_fifo: generic DEPTH×entry synchronous FIFO with async active-low reset, sync clear, push/pop, count.
- Latency pipeline and credit logic stay in the top module.

Test Plan:
- Fill/drain:
  - Stimulus: MEM_LAT=1, DEPTH=4, id_ready=0; issue PCs 0x0,0x4,0x8,0xC,0x10.
  - Response: if_ready drops after 4 accepts; occupancy=4; 0x10 not accepted.
  - Then: id_ready=1 → drains in order 0x0..0xC, occupancy counts 4→0.
- Latency:
  - Stimulus: empty queue, single fetch PC 0x100 with imem_rdata 0x00500093, pred=1, npc 0x200, at cycle t.
  - Response: id_valid at t+2 with id_instr=0x00500093, id_pc=0x100, id_pred=1, id_npc_pred=0x200. With IFQ_BYPASS_EN: at t+1.
- Flush with in-flight:
  - Stimulus: MEM_LAT=2; accept 0x20 and 0x24, then assert flush the next cycle.
  - Response: neither entry ever appears; id_valid=0, occupancy=0, if_ready=0 in the flush cycle.
- Simultaneous push/pop at full:
  - Stimulus: occupancy=4, id_ready=1.
  - Response: if_ready stays 0 that cycle; occupancy 4→3, then refills to 4; no data loss or duplication across 100 random cycles vs scoreboard.
- Async reset:
  - Stimulus: assert rst_n=0 mid-clock with 3 entries queued.
  - Response: id_valid=0, occupancy=0, id_* all 0 immediately. After release, fetch 0x40 returns in order.
- Wrap-around:
  - Stimulus: stream 20 sequential PCs with random id_ready.
  - Response: outputs match input order exactly; pointers wrap cleanly.

Source files
------------

// File: rtl/if_id_pkg.sv
// Shared types and defaults for the IF/ID fetch queue.
// Entry/metadata layouts match the default XLEN/ILEN build.
package if_id_pkg;

   localparam int XLEN_D = 32;
   localparam int ILEN_D = 32;

   localparam logic [ILEN_D-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN_D-1:0] pc;
      logic              pred;
      logic [XLEN_D-1:0] npc_pred;
   } ifq_meta_t;

   typedef struct packed {
      logic [ILEN_D-1:0] instr;
      logic [XLEN_D-1:0] pc;
      logic              pred;
      logic [XLEN_D-1:0] npc_pred;
   } ifq_entry_t;

endpackage

// File: rtl/if_id_fetch_queue_if.sv
// Fetch-request, instruction-memory and decode-side signals of the queue.
// slave is the queue's view; master is the surrounding pipeline's view.
interface if_id_fetch_queue_if #(
   parameter int XLEN = if_id_pkg::XLEN_D,
   parameter int ILEN = if_id_pkg::ILEN_D
);

   logic            if_valid;
   logic            if_ready;
   logic [XLEN-1:0] if_pc;
   logic            if_pred;
   logic [XLEN-1:0] if_npc_pred;

   logic            imem_en;
   logic [XLEN-1:0] imem_addr;
   logic [ILEN-1:0] imem_rdata;

   logic            id_valid;
   logic            id_ready;
   logic [ILEN-1:0] id_instr;
   logic [XLEN-1:0] id_pc;
   logic            id_pred;
   logic [XLEN-1:0] id_npc_pred;

   modport slave (
      input  if_valid, if_pc, if_pred, if_npc_pred,
      output if_ready,
      output imem_en, imem_addr,
      input  imem_rdata,
      output id_valid, id_instr, id_pc, id_pred, id_npc_pred,
      input  id_ready
   );

   modport master (
      output if_valid, if_pc, if_pred, if_npc_pred,
      input  if_ready,
      input  imem_en, imem_addr,
      output imem_rdata,
      input  id_valid, id_instr, id_pc, id_pred, id_npc_pred,
      output id_ready
   );

endinterface

// File: rtl/ifq_fifo.sv
// Generic DEPTH x W synchronous FIFO, async active-low reset, sync clear.
// Callers never push when full nor pop when empty.
module ifq_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic [CW-1:0] count,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Pointers wrap naturally since DEPTH is a power of two; clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Entry storage, written at the tail on push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !clear) begin
         mem[wr_ptr] <= din;
      end
   end

   assign dout  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF/ID fetch queue: memory-latency pipeline, credit flow control, FIFO.
// Optional same-cycle bypass of arrivals into empty queue: IFQ_BYPASS_EN.
module if_id_fetch_queue
   import if_id_pkg::*;
#(
   parameter int XLEN    = XLEN_D,
   parameter int ILEN    = ILEN_D,
   parameter int DEPTH   = 4,
   parameter int MEM_LAT = 1,
   localparam int CW     = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   if_id_fetch_queue_if.slave   bus,
   output logic [CW-1:0]        occupancy
);

   localparam int MW = 2 * XLEN + 1;
   localparam int EW = ILEN + MW;

   logic [MEM_LAT-1:0] stg_v;
   logic [MW-1:0]      stg_m [MEM_LAT];
   logic [1:0]         inflight;
   logic [5:0]         used;
   logic               accept;
   logic               arr_v;
   logic [EW-1:0]      arr_e;
   logic [EW-1:0]      head_e;
   logic [EW-1:0]      out_e;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic               byp;

   // Count fetches still waiting on memory; they already hold a credit.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LAT; i++) begin
         inflight = inflight + 2'(stg_v[i]);
      end
   end

   assign used         = 6'(occupancy) + 6'(inflight);
   assign bus.if_ready = rst_n && !flush && (used < 6'(DEPTH));
   assign accept       = bus.if_valid && bus.if_ready;
   assign bus.imem_en  = accept;
   assign bus.imem_addr = bus.if_pc;

   // Metadata travels alongside the memory read; flush kills it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_v <= '0;
         for (int i = 0; i < MEM_LAT; i++) stg_m[i] <= '0;
      end else if (flush) begin
         stg_v <= '0;
      end else begin
         stg_v[0] <= accept;
         stg_m[0] <= {bus.if_pc, bus.if_pred, bus.if_npc_pred};
         for (int i = 1; i < MEM_LAT; i++) begin
            stg_v[i] <= stg_v[i-1];
            stg_m[i] <= stg_m[i-1];
         end
      end
   end

   assign arr_v = stg_v[MEM_LAT-1] && !flush;
   assign arr_e = {bus.imem_rdata, stg_m[MEM_LAT-1]};

`ifdef IFQ_BYPASS_EN
   assign byp = arr_v && fifo_empty;
`else
   assign byp = 1'b0;
`endif

   assign bus.id_valid = !fifo_empty || byp;
   assign out_e        = byp ? arr_e : head_e;
   assign pop          = !fifo_empty && bus.id_ready && !flush;
   assign push         = arr_v && !(byp && bus.id_ready);

   assign {bus.id_instr, bus.id_pc, bus.id_pred, bus.id_npc_pred} =
      bus.id_valid ? out_e : '0;

   ifq_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush),
      .push  (push),
      .din   (arr_e),
      .pop   (pop),
      .dout  (head_e),
      .count (occupancy),
      .empty (fifo_empty)
   );

endmodule
